clkgen_multi: RTL and testbench

//  NCH-channel programmable clock/strobe generator.

---
 rtl/clkgen_multi.sv | 106 ++++++++++
 tb/tb_clkgen_multi.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clkgen_multi.sv
// NCH-channel programmable clock/strobe generator with glitch-free shadowed config and sync restart.
// Optional macro CLKGEN_PHASE_EN adds a per-channel start-phase input.
module clkgen_multi #(
    parameter int DIVWIDTH = 16,
    parameter int NCH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          en,
    input  logic [NCH*DIVWIDTH-1:0] div,
    input  logic [NCH*DIVWIDTH-1:0] hi,
    input  logic [NCH-1:0]          cfg_upd,
    input  logic                    sync,
`ifdef CLKGEN_PHASE_EN
    input  logic [NCH*DIVWIDTH-1:0] phase,
`endif
    output logic [NCH-1:0]          clkdiv,
    output logic [NCH-1:0]          tick,
    output logic [NCH-1:0]          pending
);

    typedef logic [DIVWIDTH-1:0] cnt_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        cnt_t div_in, hi_in;
        cnt_t cnt_q, cnt_d;
        cnt_t div_q, div_d, hi_q, hi_d;
        cnt_t sdiv_q, sdiv_d, shi_q, shi_d;
        cnt_t start;
        logic run_q, pend_q, pend_d, clk_q, tick_q;
        logic pend_eff, restart;

        assign div_in = div[i*DIVWIDTH +: DIVWIDTH];
        assign hi_in  = hi[i*DIVWIDTH +: DIVWIDTH];

        always_comb begin
            // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
            cnt_d    = cnt_q;
            div_d    = div_q;
            hi_d     = hi_q;
            sdiv_d   = sdiv_q;
            shi_d    = shi_q;
            pend_d   = pend_q;
            start    = '0;
            pend_eff = pend_q | cfg_upd[i];
            restart  = sync | ~run_q;

            if (cfg_upd[i]) begin
                sdiv_d = div_in;
                shi_d  = hi_in;
            end

            if (!en[i]) begin
                cnt_d  = '0;
                div_d  = div_in;
                hi_d   = hi_in;
                pend_d = 1'b0;
            end else if (restart || cnt_q == div_q) begin
                // Period boundary (wrap, sync or enable rise): the only place active config changes.
                if (pend_eff) begin
                    div_d = sdiv_d;
                    hi_d  = shi_d;
                end
                pend_d = 1'b0;
`ifdef CLKGEN_PHASE_EN
                start = (phase[i*DIVWIDTH +: DIVWIDTH] > div_d) ? cnt_t'(0)
                                                                : phase[i*DIVWIDTH +: DIVWIDTH];
`endif
                cnt_d = restart ? start : cnt_t'(0);
            end else begin
                cnt_d  = cnt_q + cnt_t'(1);
                pend_d = pend_eff;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q  <= '0;
                div_q  <= '0;
                hi_q   <= '0;
                sdiv_q <= '0;
                shi_q  <= '0;
                run_q  <= 1'b0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                hi_q   <= hi_d;
                sdiv_q <= sdiv_d;
                shi_q  <= shi_d;
                run_q  <= en[i];
                pend_q <= pend_d;
                clk_q  <= en[i] & (cnt_d < hi_d);
                tick_q <= en[i] & (cnt_d == '0);
            end
        end

        assign clkdiv[i]  = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed self-checking bench for clkgen_multi (default NCH=4, DIVWIDTH=16).
// Phase-start steps compile in only when CLKGEN_PHASE_EN is defined.
module tb_clkgen_multi;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic [63:0] div;
    logic [63:0] hi;
    logic [3:0]  cfg_upd;
    logic        sync;
`ifdef CLKGEN_PHASE_EN
    logic [63:0] phase;
`endif
    logic [3:0]  clkdiv;
    logic [3:0]  tick;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    clkgen_multi #(.DIVWIDTH(16), .NCH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .hi      (hi),
        .cfg_upd (cfg_upd),
        .sync    (sync),
`ifdef CLKGEN_PHASE_EN
        .phase   (phase),
`endif
        .clkdiv  (clkdiv),
        .tick    (tick),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input logic [15:0] d, input logic [15:0] h);
        div[ch*16 +: 16] = d;
        hi[ch*16 +: 16]  = h;
    endtask

    initial begin
        rst = 1'b0; en = '0; cfg_upd = '0; sync = 1'b0; div = '0; hi = '0;
`ifdef CLKGEN_PHASE_EN
        phase = '0;
`endif
        // Reset and idle
        repeat (3) step();
        check("reset_outs", {clkdiv, tick, pending}, 32'h0);
        rst = 1'b1;
        set_cfg(0, 16'd9, 16'd5);
        set_cfg(1, 16'd7, 16'd4);
        step();
        check("idle_outs", {clkdiv, tick, pending}, 32'h0);

        // ch0 div=9 hi=5: 5 high, 5 low, tick every 10 starting on enable cycle
        en[0] = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            check($sformatf("ch0_run_%0d", k), {clkdiv[0], tick[0]}, {k % 10 < 5, k % 10 == 0});
            step();
        end

        // ch1 div=7 hi=4, cfg_upd div=3 hi=1 at cnt=2
        en[1] = 1'b1;
        step();
        step();
        step();
        check("ch1_cnt2", {clkdiv[1], tick[1], pending[1]}, 3'b100);
        set_cfg(1, 16'd3, 16'd1);
        cfg_upd = 4'b0010;
        step();
        cfg_upd = '0;
        for (int j = 0; j < 13; j++) begin
            int c, h;
            logic p;
            c = (j < 5) ? 3 + j : (j - 5) % 4;
            h = (j < 5) ? 4 : 1;
            p = (j < 5);
            check($sformatf("ch1_upd_%0d", j), {clkdiv[1], tick[1], pending[1]}, {c < h, c == 0, p});
            step();
        end

        // Boundaries on ch2
        set_cfg(2, 16'd9, 16'd0);
        step();
        en[2] = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            check($sformatf("hi0_%0d", k), {clkdiv[2], tick[2]}, {1'b0, k % 10 == 0});
            step();
        end
        en[2] = 1'b0;
        set_cfg(2, 16'd9, 16'd20);
        step();
        check("ch2_disabled", {clkdiv[2], tick[2], pending[2]}, 3'b000);
        en[2] = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            check($sformatf("hi20_%0d", k), {clkdiv[2], tick[2]}, {1'b1, k % 10 == 0});
            step();
        end
        en[2] = 1'b0;
        set_cfg(2, 16'd0, 16'd1);
        step();
        en[2] = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("div0_%0d", k), {clkdiv[2], tick[2]}, 2'b11);
            step();
        end

        // Staggered channels at div 4/6/9, pending update on ch2, then sync
        en = '0;
        set_cfg(0, 16'd4, 16'd2);
        set_cfg(1, 16'd6, 16'd3);
        set_cfg(2, 16'd9, 16'd5);
        step();
        en[0] = 1'b1;
        repeat (2) step();
        en[1] = 1'b1;
        repeat (3) step();
        en[2] = 1'b1;
        repeat (3) step();
        set_cfg(2, 16'd9, 16'd2);
        cfg_upd = 4'b0100;
        step();
        cfg_upd = '0;
        check("sync_pend_before", pending, 4'b0100);
        step();
        check("ticks_before_sync", tick[2:0], 3'b010);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_ticks", tick[2:0], 3'b111);
        check("sync_clkdiv", clkdiv[2:0], 3'b111);
        check("sync_pend_after", pending, 4'b0000);
        step();
        check("post_sync_ticks", {tick[2:0], clkdiv[2:0]}, 6'b000_111);
        step();
        check("post_sync_cnt2", clkdiv[2:0], 3'b010);
        rst = 1'b0;
        step();
        check("mid_reset", {clkdiv, tick, pending}, 32'h0);
        rst = 1'b1;
        en = '0;
        step();

`ifdef CLKGEN_PHASE_EN
        // Phase start on ch3
        set_cfg(3, 16'd9, 16'd5);
        phase[48 +: 16] = 16'd3;
        step();
        en[3] = 1'b1;
        step();
        check("phase_rise", {clkdiv[3], tick[3]}, 2'b10);
        repeat (2) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int j = 0; j < 10; j++) begin
            int c;
            c = (3 + j) % 10;
            check($sformatf("phase3_%0d", j), {clkdiv[3], tick[3]}, {c < 5, c == 0});
            step();
        end
        phase[48 +: 16] = 16'd12;
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("phase12_sync", {clkdiv[3], tick[3]}, 2'b11);
        step();
        check("phase12_next", {clkdiv[3], tick[3]}, 2'b10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
